// File: rtl/imu_regfile_pkg.sv
// Shared constants for the IMU Avalon register file: address offsets
// relative to NUM_CH, CTRL bit positions, OVR bit base and an address
// classifier used by the top-level decode.
package imu_regfile_pkg;

    localparam int unsigned STATUS_OFS      = 0;
    localparam int unsigned CTRL_OFS        = 1;
    localparam int unsigned COUNT_OFS       = 2;
    localparam int unsigned RSVD_OFS        = 3;
    localparam int unsigned WR_BASE_OFS     = 4;

    localparam int unsigned CTRL_FREEZE_BIT = 0;
    localparam int unsigned CTRL_SNAP_BIT   = 1;

    localparam int unsigned OVR_BASE        = 16;
    localparam int unsigned COUNT_W         = 32;

    typedef enum logic [2:0] {
        REG_CHAN   = 3'd0,
        REG_STATUS = 3'd1,
        REG_CTRL   = 3'd2,
        REG_COUNT  = 3'd3,
        REG_RSVD   = 3'd4,
        REG_WR     = 3'd5,
        REG_NONE   = 3'd6
    } reg_kind_e;

    // Classify a word address into the register kind it selects.
    function automatic reg_kind_e decode_kind(
        input logic [31:0] a,
        input int unsigned num_ch,
        input int unsigned num_wr
    );
        reg_kind_e kind;
        if (a < num_ch) begin
            kind = REG_CHAN;
        end else if (a == num_ch + STATUS_OFS) begin
            kind = REG_STATUS;
        end else if (a == num_ch + CTRL_OFS) begin
            kind = REG_CTRL;
        end else if (a == num_ch + COUNT_OFS) begin
            kind = REG_COUNT;
        end else if (a == num_ch + RSVD_OFS) begin
            kind = REG_RSVD;
        end else if (a < num_ch + WR_BASE_OFS + num_wr) begin
            kind = REG_WR;
        end else begin
            kind = REG_NONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/imu_avalon_regfile_slot.sv
// One sensor channel slot: shadow register, snapshot register, sticky NEW
// flag and, when IMU_REGFILE_OVERRUN_EN is defined, a sticky OVR flag.
// A capture strobe always wins over a clear-on-read in the same cycle.
module imu_channel_slot
    import imu_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic              snap_req,
    input  logic              status_clr,
    output logic [DATA_W-1:0] shadow,
    output logic [DATA_W-1:0] snap,
    output logic              new_flag
`ifdef IMU_REGFILE_OVERRUN_EN
    ,
    output logic              ovr_flag
`endif
);

    logic [DATA_W-1:0] shadow_r;
    logic [DATA_W-1:0] snap_r;
    logic              new_r;

    // Capture sample into shadow; snapshot copies the pre-update shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r <= {DATA_W{1'b0}};
            snap_r   <= {DATA_W{1'b0}};
        end else begin
            if (sample_valid) begin
                shadow_r <= sample_data;
            end
            if (snap_req) begin
                snap_r <= shadow_r;
            end
        end
    end

    // Sticky NEW flag: set by capture, cleared by STATUS read, capture wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            new_r <= 1'b0;
        end else if (sample_valid) begin
            new_r <= 1'b1;
        end else if (status_clr) begin
            new_r <= 1'b0;
        end
    end

`ifdef IMU_REGFILE_OVERRUN_EN
    logic ovr_r;

    // Sticky OVR flag: a capture landing on an unread sample that is not being read now.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_r <= 1'b0;
        end else if (sample_valid && new_r && !status_clr) begin
            ovr_r <= 1'b1;
        end else if (status_clr) begin
            ovr_r <= 1'b0;
        end
    end

    assign ovr_flag = ovr_r;
`endif

    assign shadow   = shadow_r;
    assign snap     = snap_r;
    assign new_flag = new_r;

endmodule

// File: rtl/imu_avalon_regfile.sv
// Avalon-MM slave register file for the IMU subsystem. Captures NUM_CH
// sensor channels into shadow registers with sticky NEW status, supports an
// atomic snapshot / freeze mode, counts sample cycles, and exposes NUM_WR
// host-writable output registers. Read latency is fixed at one cycle.
// Optional feature macro: IMU_REGFILE_OVERRUN_EN (sticky OVR flags in
// STATUS bits [NUM_CH+15:16]).
module imu_avalon_regfile
    import imu_regfile_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_WR = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     read,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    input  logic [NUM_CH-1:0]        sample_valid,
    output logic [NUM_WR*DATA_W-1:0] wr_regs,
    output logic [NUM_WR-1:0]        wr_strobe
);

    reg_kind_e         kind_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              status_clr_s;
    logic              snap_req_s;

    logic [DATA_W-1:0] shadow_s [NUM_CH];
    logic [DATA_W-1:0] snap_s   [NUM_CH];
    logic [NUM_CH-1:0] new_s;
`ifdef IMU_REGFILE_OVERRUN_EN
    logic [NUM_CH-1:0] ovr_s;
`endif

    logic              freeze_r;
    logic [COUNT_W-1:0] count_r;
    logic [DATA_W-1:0] wr_reg_r [NUM_WR];
    logic [NUM_WR-1:0] wr_hit_s;
    logic [NUM_WR-1:0] wr_strobe_r;

    logic [DATA_W-1:0] chan_rd_s;
    logic [DATA_W-1:0] wr_rd_s;
    logic [DATA_W-1:0] status_s;
    logic [DATA_W-1:0] ctrl_rd_s;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] readdata_r;
    logic              readdatavalid_r;

    // Bus acceptance: a write always wins over a simultaneous read.
    assign wr_acc_s     = chipselect && write;
    assign rd_acc_s     = chipselect && read && !write;
    assign kind_s       = decode_kind(32'(addr), NUM_CH, NUM_WR);
    assign status_clr_s = rd_acc_s && (kind_s == REG_STATUS);
    assign snap_req_s   = wr_acc_s && (kind_s == REG_CTRL) && writedata[CTRL_SNAP_BIT];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        imu_channel_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .sample_data  (sample_data[k*DATA_W +: DATA_W]),
            .sample_valid (sample_valid[k]),
            .snap_req     (snap_req_s),
            .status_clr   (status_clr_s),
            .shadow       (shadow_s[k]),
            .snap         (snap_s[k]),
            .new_flag     (new_s[k])
`ifdef IMU_REGFILE_OVERRUN_EN
            ,
            .ovr_flag     (ovr_s[k])
`endif
        );
    end

    // FREEZE bit of CTRL; SNAP is a pulse and is not stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze_r <= 1'b0;
        end else if (wr_acc_s && (kind_s == REG_CTRL)) begin
            freeze_r <= writedata[CTRL_FREEZE_BIT];
        end
    end

    // Sample counter: one increment per cycle with any capture strobe, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (|sample_valid) begin
            count_r <= count_r + 32'd1;
        end
    end

    // Decode which host-writable register (if any) is targeted this cycle.
    always_comb begin
        wr_hit_s = {NUM_WR{1'b0}};
        for (int i = 0; i < NUM_WR; i++) begin
            wr_hit_s[i] = wr_acc_s && (addr == ADDR_W'(NUM_CH + WR_BASE_OFS + i));
        end
    end

    // Host-writable output registers and their one-cycle write strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WR; i++) begin
                wr_reg_r[i] <= {DATA_W{1'b0}};
            end
            wr_strobe_r <= {NUM_WR{1'b0}};
        end else begin
            wr_strobe_r <= wr_hit_s;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_hit_s[i]) begin
                    wr_reg_r[i] <= writedata;
                end
            end
        end
    end

    // Channel read source: live shadow, or the snapshot while frozen.
    always_comb begin
        chan_rd_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            chan_rd_s = chan_rd_s |
                        ((addr == ADDR_W'(k)) ? (freeze_r ? snap_s[k] : shadow_s[k])
                                              : {DATA_W{1'b0}});
        end
    end

    // Readback of the host-writable registers.
    always_comb begin
        wr_rd_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_WR; i++) begin
            wr_rd_s = wr_rd_s |
                      ((addr == ADDR_W'(NUM_CH + WR_BASE_OFS + i)) ? wr_reg_r[i]
                                                                   : {DATA_W{1'b0}});
        end
    end

    // STATUS word: NEW flags in the low bits, OVR flags from OVR_BASE when enabled.
    always_comb begin
        status_s               = {DATA_W{1'b0}};
        status_s[NUM_CH-1:0]   = new_s;
`ifdef IMU_REGFILE_OVERRUN_EN
        status_s[OVR_BASE +: NUM_CH] = ovr_s;
`endif
    end

    // CTRL readback: only FREEZE is visible, SNAP always reads 0.
    always_comb begin
        ctrl_rd_s                  = {DATA_W{1'b0}};
        ctrl_rd_s[CTRL_FREEZE_BIT] = freeze_r;
    end

    // Read data mux over the whole address map; unmapped and reserved read 0.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        case (kind_s)
            REG_CHAN:   rdata_s = chan_rd_s;
            REG_STATUS: rdata_s = status_s;
            REG_CTRL:   rdata_s = ctrl_rd_s;
            REG_COUNT:  rdata_s = DATA_W'(count_r);
            REG_RSVD:   rdata_s = {DATA_W{1'b0}};
            REG_WR:     rdata_s = wr_rd_s;
            REG_NONE:   rdata_s = {DATA_W{1'b0}};
            default:    rdata_s = {DATA_W{1'b0}};
        endcase
    end

    // Registered read response with fixed one-cycle latency; reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r      <= {DATA_W{1'b0}};
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= rd_acc_s;
            if (rd_acc_s) begin
                readdata_r <= rdata_s;
            end
        end
    end

    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_pack
        assign wr_regs[i*DATA_W +: DATA_W] = wr_reg_r[i];
    end

    assign readdata      = readdata_r;
    assign readdatavalid = readdatavalid_r;
    assign wr_strobe     = wr_strobe_r;

endmodule

// File: tb/tb_imu_avalon_regfile.sv
// Scoreboard testbench for imu_avalon_regfile. The driver issues one bus
// cycle per clock, updates a behavioural model of the register file and
// pushes the expected post-edge outputs; a monitor pops and compares them
// on the following falling edge.
module tb_imu_avalon_regfile;

    localparam int NCH = 8;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NWR = 3;
    localparam int ST  = NCH;
    localparam int CT  = NCH + 1;
    localparam int WB  = NCH + 4;

    logic                clk;
    logic                reset;
    logic                chipselect;
    logic [AW-1:0]       addr;
    logic                read;
    logic                write;
    logic [DW-1:0]       writedata;
    logic [DW-1:0]       readdata;
    logic                readdatavalid;
    logic [NCH*DW-1:0]   sample_data;
    logic [NCH-1:0]      sample_valid;
    logic [NWR*DW-1:0]   wr_regs;
    logic [NWR-1:0]      wr_strobe;

    imu_avalon_regfile #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .NUM_WR(NWR)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .addr(addr),
        .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .wr_regs(wr_regs), .wr_strobe(wr_strobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int                cyc;
        bit                has_rd;
        logic [DW-1:0]     rd_data;
        logic [NWR-1:0]    strobe;
        logic [NWR*DW-1:0] wrpack;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    bit   fin  = 1'b0;

    // Reference model state
    logic [DW-1:0]  shadow_m [NCH];
    logic [DW-1:0]  snap_m   [NCH];
    logic [DW-1:0]  wr_m     [NWR];
    logic [NCH-1:0] new_m;
    logic [NCH-1:0] ovr_m;
    logic [31:0]    count_m;
    bit             freeze_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            shadow_m[k] = '0;
            snap_m[k]   = '0;
        end
        for (int i = 0; i < NWR; i++) wr_m[i] = '0;
        new_m    = '0;
        ovr_m    = '0;
        count_m  = '0;
        freeze_m = 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        logic [DW-1:0] v;
        v = '0;
        if (a < NCH) begin
            v = freeze_m ? snap_m[a] : shadow_m[a];
        end else if (a == ST) begin
            v[NCH-1:0] = new_m;
`ifdef IMU_REGFILE_OVERRUN_EN
            v[16 +: NCH] = ovr_m;
`endif
        end else if (a == CT) begin
            v[0] = freeze_m;
        end else if (a == NCH + 2) begin
            v = count_m;
        end else if (a >= WB && a < WB + NWR) begin
            v = wr_m[a - WB];
        end
        return v;
    endfunction

    function automatic logic [NCH*DW-1:0] chan(input int k, input logic [DW-1:0] v);
        logic [NCH*DW-1:0] d;
        d = '0;
        d[k*DW +: DW] = v;
        return d;
    endfunction

    // One bus cycle: drive, advance the model across the edge, queue expectations.
    task automatic step(input bit rst, input bit cs, input bit rd, input bit wr, input int a,
                        input logic [DW-1:0] wd, input logic [NCH-1:0] sv,
                        input logic [NCH*DW-1:0] sd, input bit use_exp, input logic [DW-1:0] exp_v);
        rec_t r;
        bit   wacc, racc, clr, snp;
        @(negedge clk);
        reset = rst; chipselect = cs; read = rd; write = wr; addr = a[AW-1:0];
        writedata = wd; sample_valid = sv; sample_data = sd;
        r.cyc = cyc; r.has_rd = 1'b0; r.rd_data = '0; r.strobe = '0;
        if (rst) begin
            model_reset();
        end else begin
            wacc = cs && wr;
            racc = cs && rd && !wr;
            if (racc) begin
                r.has_rd  = 1'b1;
                r.rd_data = use_exp ? exp_v : model_read(a);
            end
            clr = racc && (a == ST);
            snp = wacc && (a == CT) && wd[1];
            for (int k = 0; k < NCH; k++) begin
                if (sv[k] && new_m[k] && !clr) ovr_m[k] = 1'b1;
                else if (clr)                  ovr_m[k] = 1'b0;
                if (sv[k])       new_m[k] = 1'b1;
                else if (clr)    new_m[k] = 1'b0;
                if (snp)    snap_m[k]   = shadow_m[k];
                if (sv[k])  shadow_m[k] = sd[k*DW +: DW];
            end
            if (sv != '0) count_m = count_m + 32'd1;
            if (wacc && a == CT) freeze_m = wd[0];
            if (wacc && a >= WB && a < WB + NWR) begin
                wr_m[a - WB]       = wd;
                r.strobe[a - WB]   = 1'b1;
            end
        end
        for (int i = 0; i < NWR; i++) r.wrpack[i*DW +: DW] = wr_m[i];
        q.push_back(r);
    endtask

    // Monitor: compares DUT outputs one falling edge after each driven cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].cyc + 1 == cyc) begin
                r = q.pop_front();
                checks++;
                if (readdatavalid !== r.has_rd) begin
                    errors++;
                    $display("FAIL rdvalid cyc=%0d act=%b exp=%b", cyc, readdatavalid, r.has_rd);
                end
                if (r.has_rd) begin
                    checks++;
                    if (readdata !== r.rd_data) begin
                        errors++;
                        $display("FAIL readdata cyc=%0d act=%h exp=%h", cyc, readdata, r.rd_data);
                    end
                end
                checks++;
                if (wr_strobe !== r.strobe) begin
                    errors++;
                    $display("FAIL wr_strobe cyc=%0d act=%b exp=%b", cyc, wr_strobe, r.strobe);
                end
                checks++;
                if (wr_regs !== r.wrpack) begin
                    errors++;
                    $display("FAIL wr_regs cyc=%0d act=%h exp=%h", cyc, wr_regs, r.wrpack);
                end
            end else begin
                checks++;
                if (readdatavalid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_rdvalid cyc=%0d act=%b exp=0", cyc, readdatavalid);
                end
            end
            if (done && !fin) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover act=%0d exp=0", q.size());
                end
                fin = 1'b1;
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        logic [NCH*DW-1:0] sd;
        logic [NCH-1:0]    sv;
        int                a, op;
        bit                rst;
        reset = 1'b1; chipselect = 1'b0; addr = '0; read = 1'b0; write = 1'b0;
        writedata = '0; sample_valid = '0; sample_data = '0;
        model_reset();

        repeat (3) step(1, 0, 0, 0, 0, 0, '0, '0, 0, 0);

        // Every address reads 0 after reset, COUNT included
        for (int i = 0; i < 32; i++) step(0, 1, 1, 0, i, 0, '0, '0, 1, 32'h0);

        // Capture ch2 and clear-on-read STATUS
        step(0, 0, 0, 0, 0, 0, 8'h04, chan(2, 32'h1234), 0, 0);
        step(0, 1, 1, 0, 2, 0, '0, '0, 1, 32'h1234);
        step(0, 1, 1, 0, ST, 0, '0, '0, 1, 32'h4);
        step(0, 1, 1, 0, ST, 0, '0, '0, 1, 32'h0);
        step(0, 1, 1, 0, NCH + 2, 0, '0, '0, 1, 32'h1);

        // Snapshot and freeze
        step(0, 0, 0, 0, 0, 0, 8'h01, chan(0, 32'h1111), 0, 0);
        step(0, 1, 0, 1, CT, 32'h3, '0, '0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 8'h01, chan(0, 32'hBEEF), 0, 0);
        step(0, 1, 1, 0, 0, 0, '0, '0, 1, 32'h1111);
        step(0, 1, 1, 0, CT, 0, '0, '0, 1, 32'h1);
        step(0, 1, 0, 1, CT, 32'h0, '0, '0, 0, 0);
        step(0, 1, 1, 0, 0, 0, '0, '0, 1, 32'hBEEF);
        step(0, 1, 0, 1, CT, 32'h3, 8'h01, chan(0, 32'h2222), 0, 0);
        step(0, 1, 1, 0, 0, 0, '0, '0, 1, 32'hBEEF);
        step(0, 1, 0, 1, CT, 32'h0, '0, '0, 0, 0);
        step(0, 1, 1, 0, 0, 0, '0, '0, 1, 32'h2222);
        step(0, 1, 1, 0, ST, 0, '0, '0, 0, 0);

        // STATUS read colliding with a capture on ch5
        step(0, 1, 1, 0, ST, 0, 8'h20, chan(5, 32'h55), 1, 32'h0);
        step(0, 1, 1, 0, ST, 0, '0, '0, 1, 32'h20);
        step(0, 1, 1, 0, ST, 0, '0, '0, 1, 32'h0);

        // Host-writable register, strobe, read+write collision
        step(0, 1, 0, 1, WB, 32'hA5, '0, '0, 0, 0);
        step(0, 0, 0, 0, 0, 0, '0, '0, 0, 0);
        step(0, 1, 1, 0, WB, 0, '0, '0, 1, 32'hA5);
        step(0, 1, 1, 1, WB, 32'h5A, '0, '0, 0, 0);
        step(0, 1, 1, 0, WB, 0, '0, '0, 1, 32'h5A);
        step(0, 0, 1, 0, WB, 0, '0, '0, 0, 0);

        // Double capture on ch1 without an intervening STATUS read
        step(0, 0, 0, 0, 0, 0, 8'h02, chan(1, 32'h77), 0, 0);
        step(0, 0, 0, 0, 0, 0, '0, '0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 8'h02, chan(1, 32'h78), 0, 0);
`ifdef IMU_REGFILE_OVERRUN_EN
        step(0, 1, 1, 0, ST, 0, '0, '0, 1, 32'h0002_0002);
`else
        step(0, 1, 1, 0, ST, 0, '0, '0, 1, 32'h0000_0002);
`endif
        step(0, 1, 1, 0, ST, 0, '0, '0, 1, 32'h0);

        // Read accepted while reset asserted gives no response
        step(0, 0, 0, 0, 0, 0, 8'h08, chan(3, 32'h99), 0, 0);
        step(1, 1, 1, 0, 3, 0, '0, '0, 0, 0);
        step(0, 1, 1, 0, 3, 0, '0, '0, 1, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NCH; k++) sd[k*DW +: DW] = $urandom;
            sv  = NCH'($urandom & $urandom & $urandom);
            rst = ($urandom_range(0, 299) == 0);
            op  = $urandom_range(0, 9);
            a   = ($urandom_range(0, 3) == 0) ? $urandom_range(ST, CT) : $urandom_range(0, 31);
            case (op)
                0, 1, 2, 3: step(rst, 1, 1, 0, a, $urandom, sv, sd, 0, 0);
                4, 5, 6:    step(rst, 1, 0, 1, a, $urandom, sv, sd, 0, 0);
                7:          step(rst, 1, 1, 1, a, $urandom, sv, sd, 0, 0);
                8:          step(rst, 0, 0, 0, a, $urandom, sv, sd, 0, 0);
                default:    step(rst, 0, 1, 1, a, $urandom, sv, sd, 0, 0);
            endcase
        end

        step(0, 0, 0, 0, 0, 0, '0, '0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        for (int i = 0; i < 10 && !fin; i++) @(negedge clk);
        if (!fin) begin
            $display("FAIL monitor_timeout act=0 exp=1");
            $fatal(1, "monitor did not complete");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imu_avalon_regfile.md
Name: imu_avalon_regfile

Overview:
Parametrised Avalon-MM slave register file for the IMU subsystem. It captures N sensor channels from the IMU front-end into shadow registers, one per channel, each on its own valid strobe. It exposes sticky new-data status, an atomic snapshot mode and a sample counter, and provides host-writable output registers for the downstream orientation logic. It sits between the Avalon interconnect and the imu/raw_data_to_degree datapath.

Parameters:
NUM_CH, 8, number of sensor input channels (1-16)
DATA_W, 32, width of each channel, readdata and writedata
ADDR_W, 5, Avalon word-address width; must satisfy 2^ADDR_W >= NUM_CH+4+NUM_WR
NUM_WR, 3, number of host-writable output registers (1-8)

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
addr  in  ADDR_W  word address
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
readdata  out  DATA_W  registered read data
readdatavalid  out  1  high for one cycle when readdata is valid
sample_data  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
sample_valid  in  NUM_CH  per-channel capture strobe
wr_regs  out  NUM_WR*DATA_W  host-written registers, packed the same way as sample_data
wr_strobe  out  NUM_WR  one-cycle pulse when the matching wr_reg is written

Behaviour:
- Address map:
  - 0..NUM_CH-1: channel data (read only).
  - NUM_CH: STATUS. Bits [NUM_CH-1:0] are the NEW flags.
  - NUM_CH+1: CTRL. Bit0 is FREEZE; bit1 is SNAP (write-1 pulse, reads as 0).
  - NUM_CH+2: COUNT, the sample counter.
  - NUM_CH+3: reserved; reads 0.
  - NUM_CH+4..NUM_CH+3+NUM_WR: wr_regs (read/write).
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: all shadow, snapshot, wr_regs, STATUS, CTRL and COUNT registers clear to 0. readdata=0, readdatavalid=0, wr_strobe=0.
- Capture: sample_valid[k] loads shadow[k] from channel k on the same edge and sets NEW[k]. COUNT increments by 1 per cycle in which any sample_valid bit is high. COUNT wraps from 2^32-1 to 0.
- Read:
  - Accepted on chipselect&read. readdata is registered and readdatavalid asserts the next cycle (fixed latency 1). No waitrequest.
  - read and write asserted together: the write has priority and the read is ignored (no readdatavalid).
- Data source: FREEZE=0 returns shadow[k]; FREEZE=1 returns snap[k].
- SNAP: writing CTRL with bit1=1 copies all shadows into snap on that edge.
  - If sample_valid[k] is high in the same cycle, snap[k] takes the pre-update shadow value; shadow updates normally.
  - The FREEZE bit is written together with SNAP in the same write.
- STATUS is clear-on-read: an accepted STATUS read returns the current flags and clears them on the same edge. A sample_valid[k] in that cycle wins, so NEW[k] remains 1, and the returned value reflects the pre-edge flags.
- Writes to a wr_reg update it the next edge and pulse wr_strobe[i] for exactly one cycle.
- Reset asserted mid-transaction: any pending readdatavalid is dropped (0 on the next cycle).

Optional Feature:
Macro IMU_REGFILE_OVERRUN_EN.
- Defined: STATUS bits [NUM_CH+15:16] are sticky OVR flags. OVR[k] sets when sample_valid[k] arrives while NEW[k]=1 and NEW[k] is not being cleared in that cycle. OVR clears on STATUS read under the same rules as NEW.
- Undefined: those bits read 0 and no OVR logic is synthesised.

Decomposition:
- Package imu_regfile_pkg holds the address-offset constants (STATUS_OFS, CTRL_OFS, COUNT_OFS, WR_BASE_OFS, relative to NUM_CH), the CTRL bit indices and the OVR bit base (16).
- One natural sub-module: imu_channel_slot. It holds one channel's shadow, snap, NEW and (optionally) OVR flag, and is instantiated NUM_CH times by a generate loop.

Test Plan:
1. Reset, then read every address -> readdata=0 with readdatavalid one cycle after each read; COUNT=0.
2. sample_valid[2] with data 0x1234, then read addr 2 -> 0x1234; STATUS read returns 0x4; a second STATUS read returns 0.
3. Write CTRL=0x3, then pulse sample_valid[0] with 0xBEEF -> addr 0 still returns the old snapshot value; write CTRL=0 -> addr 0 returns 0xBEEF.
4. STATUS read in the same cycle as sample_valid[5] -> returned value has bit5=0, and the next STATUS read has bit5=1.
5. Write 0xA5 to addr NUM_CH+4 -> wr_regs[0]=0xA5, wr_strobe[0] high for 1 cycle; read back 0xA5. Assert read and write together -> no readdatavalid.
6. IMU_REGFILE_OVERRUN_EN defined: two sample_valid[1] pulses with no STATUS read between them -> STATUS = 0x00020002; the following STATUS read = 0. Macro undefined -> STATUS = 0x2.
